// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: tag space, widths, entry type codes.
package reorder_buffer_pkg;

    localparam int unsigned RobSize = 16;
    localparam int unsigned TagW    = 4;
    localparam int unsigned DataW   = 32;
    localparam int unsigned AddrW   = 32;
    localparam int unsigned RegW    = 5;

    localparam logic [TagW-1:0] EmptyTag = '0;

    typedef enum logic [1:0] {
        RobReg    = 2'd0,
        RobStore  = 2'd1,
        RobBranch = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic             busy;
        logic             ready;
        rob_type_e        kind;
        logic [RegW-1:0]  rd;
        logic [AddrW-1:0] pc;
        logic             pred;
        logic [DataW-1:0] value;
        logic             taken;
        logic [AddrW-1:0] target;
    } rob_entry_t;

    // Tag 0 is reserved as "no tag", so pointers wrap from RobSize-1 back to 1.
    function automatic logic [TagW-1:0] next_tag(input logic [TagW-1:0] t);
        return (t == TagW'(RobSize - 1)) ? TagW'(1) : t + TagW'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand lookup into the ROB by tag; ROB_WB_BYPASS_EN forwards same-cycle writebacks.
module reorder_buffer_query_port
    import reorder_buffer_pkg::*;
(
    input  logic [TagW-1:0]               tag_i,
    input  logic [RobSize-1:0]            ready_i,
    input  logic [RobSize-1:0][DataW-1:0] value_i,
    input  logic [TagW-1:0]               ex_tag_i,
    input  logic [DataW-1:0]              ex_data_i,
    input  logic [TagW-1:0]               lsb_tag_i,
    input  logic [DataW-1:0]              lsb_data_i,
    output logic                          ready_o,
    output logic [DataW-1:0]              data_o
);

`ifdef ROB_WB_BYPASS_EN
    always_comb begin
        ready_o = ready_i[tag_i];
        data_o  = value_i[tag_i];
        if (ex_tag_i != EmptyTag && ex_tag_i == tag_i) begin
            ready_o = 1'b1;
            data_o  = ex_data_i;
        end else if (lsb_tag_i != EmptyTag && lsb_tag_i == tag_i) begin
            ready_o = 1'b1;
            data_o  = lsb_data_i;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{ex_tag_i, ex_data_i, lsb_tag_i, lsb_data_i};

    always_comb begin
        ready_o = ready_i[tag_i];
        data_o  = value_i[tag_i];
    end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tag allocation, EX/LSB writeback capture, single commit per cycle,
// mispredict flush. Optional ROB_WB_BYPASS_EN enables same-cycle writeback forwarding on queries.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_i,
    input  logic             alloc_valid_i,
    input  logic [1:0]       alloc_type_i,
    input  logic [RegW-1:0]  alloc_rd_i,
    input  logic [AddrW-1:0] alloc_pc_i,
    input  logic             alloc_pred_i,
    output logic             rob_idle_o,
    output logic [TagW-1:0]  alloc_tag_o,
    input  logic [TagW-1:0]  q1_tag_i,
    input  logic [TagW-1:0]  q2_tag_i,
    output logic             q1_ready_o,
    output logic             q2_ready_o,
    output logic [DataW-1:0] q1_data_o,
    output logic [DataW-1:0] q2_data_o,
    input  logic [TagW-1:0]  ex_tag_i,
    input  logic [DataW-1:0] ex_data_i,
    input  logic             ex_taken_i,
    input  logic [AddrW-1:0] ex_target_i,
    input  logic [TagW-1:0]  lsb_tag_i,
    input  logic [DataW-1:0] lsb_data_i,
    output logic [TagW-1:0]  tag_renew_o,
    output logic [DataW-1:0] data_renew_o,
    output logic [RegW-1:0]  commit_rd_o,
    output logic [TagW-1:0]  store_commit_o,
    output logic             clear_o,
    output logic [AddrW-1:0] redirect_pc_o
);

    rob_entry_t entries_q [RobSize];
    rob_entry_t entries_d [RobSize];

    logic [TagW-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [TagW-1:0]  tag_renew_q, tag_renew_d, store_commit_q, store_commit_d;
    logic [DataW-1:0] data_renew_q, data_renew_d;
    logic [RegW-1:0]  commit_rd_q, commit_rd_d;
    logic             clear_q, clear_d;
    logic [AddrW-1:0] redirect_pc_q, redirect_pc_d;

    logic                          do_alloc, do_commit;
    logic [RobSize-1:0]            ready_vec;
    logic [RobSize-1:0][DataW-1:0] value_vec;

    assign rob_idle_o     = count_q < TagW'(RobSize - 1);
    assign alloc_tag_o    = tail_q;
    assign tag_renew_o    = tag_renew_q;
    assign data_renew_o   = data_renew_q;
    assign commit_rd_o    = commit_rd_q;
    assign store_commit_o = store_commit_q;
    assign clear_o        = clear_q;
    assign redirect_pc_o  = redirect_pc_q;

    always_comb begin
        for (int i = 0; i < RobSize; i++) begin
            ready_vec[i] = entries_q[i].ready;
            value_vec[i] = entries_q[i].value;
        end
    end

    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        tag_renew_d    = EmptyTag;
        data_renew_d   = '0;
        commit_rd_d    = '0;
        store_commit_d = EmptyTag;
        clear_d        = 1'b0;
        redirect_pc_d  = '0;
        do_alloc       = 1'b0;
        do_commit      = 1'b0;

        if (clear_q) begin
            // The flush cycle discards everything, including this cycle's alloc and writebacks.
            for (int i = 0; i < RobSize; i++) begin
                entries_d[i] = '0;
            end
            head_d  = TagW'(1);
            tail_d  = TagW'(1);
            count_d = '0;
        end else begin
            if (ex_tag_i != EmptyTag && entries_q[ex_tag_i].busy) begin
                entries_d[ex_tag_i].ready  = 1'b1;
                entries_d[ex_tag_i].value  = ex_data_i;
                entries_d[ex_tag_i].taken  = ex_taken_i;
                entries_d[ex_tag_i].target = ex_target_i;
            end
            if (lsb_tag_i != EmptyTag && entries_q[lsb_tag_i].busy) begin
                entries_d[lsb_tag_i].ready = 1'b1;
                entries_d[lsb_tag_i].value = lsb_data_i;
            end

            if (entries_q[head_q].busy && entries_q[head_q].ready) begin
                do_commit               = 1'b1;
                entries_d[head_q].busy  = 1'b0;
                head_d                  = next_tag(head_q);
                tag_renew_d             = head_q;
                data_renew_d            = entries_q[head_q].value;
                unique case (entries_q[head_q].kind)
                    RobStore: begin
                        store_commit_d = head_q;
                    end
                    RobBranch: begin
                        commit_rd_d = entries_q[head_q].rd;
                        if (entries_q[head_q].taken != entries_q[head_q].pred) begin
                            clear_d       = 1'b1;
                            redirect_pc_d = entries_q[head_q].taken ? entries_q[head_q].target
                                                                    : entries_q[head_q].pc
                                                                      + AddrW'(4);
                        end
                    end
                    default: begin
                        commit_rd_d = entries_q[head_q].rd;
                    end
                endcase
            end

            if (alloc_valid_i && rob_idle_o) begin
                do_alloc                 = 1'b1;
                entries_d[tail_q].busy   = 1'b1;
                entries_d[tail_q].ready  = 1'b0;
                entries_d[tail_q].kind   = rob_type_e'(alloc_type_i);
                entries_d[tail_q].rd     = alloc_rd_i;
                entries_d[tail_q].pc     = alloc_pc_i;
                entries_d[tail_q].pred   = alloc_pred_i;
                entries_d[tail_q].value  = '0;
                entries_d[tail_q].taken  = 1'b0;
                entries_d[tail_q].target = '0;
                tail_d                   = next_tag(tail_q);
            end

            count_d = count_q + TagW'(do_alloc) - TagW'(do_commit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RobSize; i++) begin
                entries_q[i] <= '0;
            end
            head_q         <= TagW'(1);
            tail_q         <= TagW'(1);
            count_q        <= '0;
            tag_renew_q    <= EmptyTag;
            data_renew_q   <= '0;
            commit_rd_q    <= '0;
            store_commit_q <= EmptyTag;
            clear_q        <= 1'b0;
            redirect_pc_q  <= '0;
        end else if (rdy_i) begin
            entries_q      <= entries_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            tag_renew_q    <= tag_renew_d;
            data_renew_q   <= data_renew_d;
            commit_rd_q    <= commit_rd_d;
            store_commit_q <= store_commit_d;
            clear_q        <= clear_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    reorder_buffer_query_port u_query1 (
        .tag_i      (q1_tag_i),
        .ready_i    (ready_vec),
        .value_i    (value_vec),
        .ex_tag_i   (ex_tag_i),
        .ex_data_i  (ex_data_i),
        .lsb_tag_i  (lsb_tag_i),
        .lsb_data_i (lsb_data_i),
        .ready_o    (q1_ready_o),
        .data_o     (q1_data_o)
    );

    reorder_buffer_query_port u_query2 (
        .tag_i      (q2_tag_i),
        .ready_i    (ready_vec),
        .value_i    (value_vec),
        .ex_tag_i   (ex_tag_i),
        .ex_data_i  (ex_data_i),
        .lsb_tag_i  (lsb_tag_i),
        .lsb_data_i (lsb_data_i),
        .ready_o    (q2_ready_o),
        .data_o     (q2_data_o)
    );

endmodule
